// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with saturating direction counters and debug statistics.
//   CLK, RST                 clock and asynchronous active-high reset
//   lk_pc -> lk_hit, lk_taken, lk_next_pc   combinational fetch lookup
//   upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken   resolved-branch training
//   flush_all                invalidate every entry
//   stat_clr -> stat_hits, stat_mispred     saturating debug counters
module branch_target_buffer #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_hit,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic              flush_all,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_mispred
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [ADDR_W-1:0]  target [ENTRIES];
    logic [CTR_W-1:0]   ctr    [ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic             upd_hit;
    logic [CTR_W-1:0] upd_ctr;

    assign lk_idx  = lk_pc[IDX_W-1:0];
    assign upd_idx = upd_pc[IDX_W-1:0];

    // Lookup reads only registered state, so a same-cycle update is not visible yet.
    always_comb begin
        lk_hit     = valid[lk_idx] && tag[lk_idx] == lk_pc[ADDR_W-1:IDX_W];
        lk_taken   = lk_hit && ctr[lk_idx][CTR_W-1];
        lk_next_pc = lk_taken ? target[lk_idx] : lk_pc + ADDR_W'(1);
    end

    always_comb begin
        upd_hit = valid[upd_idx] && tag[upd_idx] == upd_pc[ADDR_W-1:IDX_W];
        upd_ctr = upd_taken ? (&ctr[upd_idx] ? ctr[upd_idx] : ctr[upd_idx] + CTR_W'(1))
                            : (ctr[upd_idx] == '0 ? ctr[upd_idx] : ctr[upd_idx] - CTR_W'(1));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= '0;
            end
        end else if (flush_all) begin
            valid <= '0;
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr[upd_idx] <= upd_ctr;
                if (upd_taken)
                    target[upd_idx] <= upd_target;
            end else if (upd_taken) begin
                // Allocation replaces whatever occupies the slot, starting weakly taken.
                valid[upd_idx]  <= 1'b1;
                tag[upd_idx]    <= upd_pc[ADDR_W-1:IDX_W];
                target[upd_idx] <= upd_target;
                ctr[upd_idx]    <= CTR_W'(1) << (CTR_W - 1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_hits    <= '0;
            stat_mispred <= '0;
        end else if (stat_clr) begin
            stat_hits    <= '0;
            stat_mispred <= '0;
        end else begin
            if (lk_hit && !(&stat_hits))
                stat_hits <= stat_hits + STAT_W'(1);
            if (upd_valid && upd_taken != upd_pred_taken && !(&stat_mispred))
                stat_mispred <= stat_mispred + STAT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed self-checking bench for branch_target_buffer (STAT_W = 4).
module tb_branch_target_buffer;
    logic        CLK = 0;
    logic        RST = 1;
    logic [15:0] lk_pc = 16'h0040;
    logic        lk_hit, lk_taken;
    logic [15:0] lk_next_pc;
    logic        upd_valid = 0;
    logic [15:0] upd_pc = 0;
    logic        upd_taken = 0;
    logic [15:0] upd_target = 0;
    logic        upd_pred_taken = 0;
    logic        flush_all = 0;
    logic        stat_clr = 0;
    logic [3:0]  stat_hits, stat_mispred;
    int total = 0;
    int bad = 0;

    branch_target_buffer #(.ADDR_W(16), .ENTRIES(16), .CTR_W(2), .STAT_W(4)) dut (
        .CLK(CLK), .RST(RST), .lk_pc(lk_pc), .lk_hit(lk_hit), .lk_taken(lk_taken),
        .lk_next_pc(lk_next_pc), .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .flush_all(flush_all),
        .stat_clr(stat_clr), .stat_hits(stat_hits), .stat_mispred(stat_mispred)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic upd(input logic [15:0] pc, input logic t, input logic [15:0] tgt, input logic p);
        upd_valid = 1; upd_pc = pc; upd_taken = t; upd_target = tgt; upd_pred_taken = p;
    endtask

    task automatic test_reset();
        #2;
        total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%0b want=0", lk_hit); end
        total++; if (lk_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%0b want=0", lk_taken); end
        total++; if (lk_next_pc !== 16'h0041) begin bad++; $display("FAIL reset_next got=%h want=0041", lk_next_pc); end
        total++; if (stat_hits !== 4'd0) begin bad++; $display("FAIL reset_hits got=%0d want=0", stat_hits); end
        total++; if (stat_mispred !== 4'd0) begin bad++; $display("FAIL reset_mispred got=%0d want=0", stat_mispred); end
        step();
        RST = 0;
    endtask

    task automatic test_alloc();
        upd(16'h0123, 1, 16'h0200, 0);
        step();
        upd_valid = 0;
        total++; if (stat_mispred !== 4'd1) begin bad++; $display("FAIL alloc_mispred got=%0d want=1", stat_mispred); end
        lk_pc = 16'h0123; #1;
        total++; if (lk_hit !== 1'b1) begin bad++; $display("FAIL alloc_hit got=%0b want=1", lk_hit); end
        total++; if (lk_taken !== 1'b1) begin bad++; $display("FAIL alloc_taken got=%0b want=1", lk_taken); end
        total++; if (lk_next_pc !== 16'h0200) begin bad++; $display("FAIL alloc_next got=%h want=0200", lk_next_pc); end
        step();
        total++; if (stat_hits !== 4'd1) begin bad++; $display("FAIL alloc_hits got=%0d want=1", stat_hits); end
        lk_pc = 16'h0040;
    endtask

    task automatic test_hysteresis();
        upd(16'h0123, 0, 16'h0000, 0);
        step();
        step();
        upd_valid = 0;
        lk_pc = 16'h0123; #1;
        total++; if (lk_hit !== 1'b1) begin bad++; $display("FAIL hyst0_hit got=%0b want=1", lk_hit); end
        total++; if (lk_taken !== 1'b0) begin bad++; $display("FAIL hyst0_taken got=%0b want=0", lk_taken); end
        total++; if (lk_next_pc !== 16'h0124) begin bad++; $display("FAIL hyst0_next got=%h want=0124", lk_next_pc); end
        lk_pc = 16'h0040;
        upd(16'h0123, 1, 16'h0200, 1);
        step();
        upd_valid = 0;
        lk_pc = 16'h0123; #1;
        total++; if (lk_taken !== 1'b0) begin bad++; $display("FAIL hyst1_taken got=%0b want=0", lk_taken); end
        lk_pc = 16'h0040;
        upd(16'h0123, 1, 16'h0200, 1);
        step();
        upd_valid = 0;
        lk_pc = 16'h0123; #1;
        total++; if (lk_taken !== 1'b1) begin bad++; $display("FAIL hyst2_taken got=%0b want=1", lk_taken); end
        total++; if (lk_next_pc !== 16'h0200) begin bad++; $display("FAIL hyst2_next got=%h want=0200", lk_next_pc); end
        lk_pc = 16'h0040;
        total++; if (stat_mispred !== 4'd1) begin bad++; $display("FAIL hyst_mispred got=%0d want=1", stat_mispred); end
    endtask

    task automatic test_alias();
        lk_pc = 16'h0123;
        upd(16'h0F23, 1, 16'h0300, 0);
        #1;
        total++; if (lk_next_pc !== 16'h0200) begin bad++; $display("FAIL alias_same_cycle got=%h want=0200", lk_next_pc); end
        step();
        upd_valid = 0;
        #1;
        total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL alias_old_hit got=%0b want=0", lk_hit); end
        total++; if (lk_next_pc !== 16'h0124) begin bad++; $display("FAIL alias_old_next got=%h want=0124", lk_next_pc); end
        lk_pc = 16'h0F23; #1;
        total++; if (lk_hit !== 1'b1) begin bad++; $display("FAIL alias_new_hit got=%0b want=1", lk_hit); end
        total++; if (lk_next_pc !== 16'h0300) begin bad++; $display("FAIL alias_new_next got=%h want=0300", lk_next_pc); end
        lk_pc = 16'h0040;
        upd(16'h0055, 0, 16'h0500, 0);
        step();
        upd_valid = 0;
        lk_pc = 16'h0055; #1;
        total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL nt_miss_hit got=%0b want=0", lk_hit); end
        total++; if (lk_next_pc !== 16'h0056) begin bad++; $display("FAIL nt_miss_next got=%h want=0056", lk_next_pc); end
        lk_pc = 16'h0040;
        total++; if (stat_hits !== 4'd2) begin bad++; $display("FAIL alias_hits got=%0d want=2", stat_hits); end
        total++; if (stat_mispred !== 4'd2) begin bad++; $display("FAIL alias_mispred got=%0d want=2", stat_mispred); end
    endtask

    task automatic test_flush();
        flush_all = 1;
        upd(16'h0010, 1, 16'h0400, 1);
        step();
        flush_all = 0;
        upd_valid = 0;
        lk_pc = 16'h0010; #1;
        total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL flush_upd_hit got=%0b want=0", lk_hit); end
        lk_pc = 16'h0F23; #1;
        total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL flush_old_hit got=%0b want=0", lk_hit); end
        lk_pc = 16'h0040;
        total++; if (stat_hits !== 4'd2) begin bad++; $display("FAIL flush_hits got=%0d want=2", stat_hits); end
        total++; if (stat_mispred !== 4'd2) begin bad++; $display("FAIL flush_mispred got=%0d want=2", stat_mispred); end
    endtask

    task automatic test_saturation();
        upd(16'h0123, 1, 16'h0200, 1);
        step();
        upd_valid = 0;
        lk_pc = 16'h0123;
        for (int i = 0; i < 20; i++) step();
        total++; if (stat_hits !== 4'd15) begin bad++; $display("FAIL sat_hits got=%0d want=15", stat_hits); end
        stat_clr = 1;
        step();
        stat_clr = 0;
        total++; if (stat_hits !== 4'd0) begin bad++; $display("FAIL clr_hits got=%0d want=0", stat_hits); end
        total++; if (stat_mispred !== 4'd0) begin bad++; $display("FAIL clr_mispred got=%0d want=0", stat_mispred); end
        step();
        total++; if (stat_hits !== 4'd1) begin bad++; $display("FAIL post_clr_hits got=%0d want=1", stat_hits); end
        lk_pc = 16'hFFFF; #1;
        total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL wrap_hit got=%0b want=0", lk_hit); end
        total++; if (lk_next_pc !== 16'h0000) begin bad++; $display("FAIL wrap_next got=%h want=0000", lk_next_pc); end
        lk_pc = 16'h0040;
    endtask

    task automatic test_async_reset();
        lk_pc = 16'h0123; #1;
        total++; if (lk_hit !== 1'b1) begin bad++; $display("FAIL pre_rst_hit got=%0b want=1", lk_hit); end
        RST = 1;
        upd(16'h0123, 1, 16'h0600, 0);
        #1;
        total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL async_rst_hit got=%0b want=0", lk_hit); end
        total++; if (lk_next_pc !== 16'h0124) begin bad++; $display("FAIL async_rst_next got=%h want=0124", lk_next_pc); end
        total++; if (stat_hits !== 4'd0) begin bad++; $display("FAIL async_rst_hits got=%0d want=0", stat_hits); end
        step();
        RST = 0;
        upd_valid = 0;
        #1;
        total++; if (lk_hit !== 1'b0) begin bad++; $display("FAIL rst_discard_hit got=%0b want=0", lk_hit); end
        total++; if (stat_mispred !== 4'd0) begin bad++; $display("FAIL rst_discard_mispred got=%0d want=0", stat_mispred); end
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_hysteresis();
        test_alias();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
